// File: rtl/score_digit_ctrl.sv
// Score HUD sequencer: binary-to-BCD conversion plus digit-slot font lookup.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_digit_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int ORIGIN_X   = 480,
    parameter int ORIGIN_Y   = 16,
    parameter int PITCH_LOG2 = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [BIN_W-1:0]          score_in,
    input  logic                      score_load,
    output logic                      busy,
    output logic                      conv_done,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [3:0]                font_digit,
    input  logic [13:0][13:0][5:0]    font_in,
    output logic                      pixel_on,
    output logic [5:0]                pixel_color
);

    localparam int BW      = 4 * NUM_DIGITS;
    localparam int CW      = $clog2(BIN_W + 1);
    localparam int FIELD_W = NUM_DIGITS << PITCH_LOG2;
    localparam logic [63:0] MAXV = 64'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t           state, state_nx;
    logic [BW-1:0]    scratch, scratch_nx, adj;
    logic [BIN_W-1:0] shreg, shreg_nx, pend;
    logic             pend_vld;
    logic [CW-1:0]    cnt;

    function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
        if (64'(v) > MAXV) return BIN_W'(MAXV);
        return v;
    endfunction

    // shift-add-3: correct each BCD nibble before the doubling shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        {scratch_nx, shreg_nx} = {adj, shreg} << 1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        conv_done = (state == COMMIT);
        unique case (state)
            IDLE:    if (score_load || pend_vld) state_nx = CONV;
            CONV:    if (cnt == CW'(1)) state_nx = COMMIT;
            COMMIT:  state_nx = pend_vld ? CONV : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scratch  <= '0;
            shreg    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            cnt      <= '0;
            bcd_out  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (score_load || pend_vld) begin
                        shreg    <= score_load ? clamp(score_in) : pend;
                        scratch  <= '0;
                        cnt      <= CW'(BIN_W);
                        pend_vld <= 1'b0;
                    end
                end
                CONV: begin
                    scratch <= scratch_nx;
                    shreg   <= shreg_nx;
                    cnt     <= cnt - CW'(1);
                    // commit lands together with the COMMIT state
                    if (cnt == CW'(1)) bcd_out <= scratch_nx;
                    if (score_load) begin
                        pend     <= clamp(score_in);
                        pend_vld <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (pend_vld) begin
                        shreg   <= pend;
                        scratch <= '0;
                        cnt     <= CW'(BIN_W);
                    end
                    pend_vld <= score_load;
                    if (score_load) pend <= clamp(score_in);
                end
                default: ;
            endcase
        end
    end

    logic [9:0] dx, dy, idx, col;
    logic       hit_raw, hit;
    logic [3:0] dsel;
    logic       hit_q;
    logic [3:0] row_q, col_q;
    logic [5:0] pix;
    logic       lit;

    assign dx  = DrawX - 10'(ORIGIN_X);
    assign dy  = DrawY - 10'(ORIGIN_Y);
    assign idx = dx >> PITCH_LOG2;
    assign col = dx & 10'((1 << PITCH_LOG2) - 1);

    assign hit_raw = (DrawX >= 10'(ORIGIN_X)) && (dx < 10'(FIELD_W)) &&
                     (DrawY >= 10'(ORIGIN_Y)) && (dy < 10'd14) &&
                     (col < 10'd14);

`ifdef LEADING_ZERO_BLANK_EN
    logic blank, lead;
    always_comb begin
        dsel  = '0;
        blank = 1'b0;
        lead  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lead = lead && (bcd_out[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            if (idx == 10'(i)) begin
                dsel  = bcd_out[4*(NUM_DIGITS-1-i) +: 4];
                blank = lead && (i < NUM_DIGITS - 1);
            end
        end
        hit = hit_raw && !blank;
    end
`else
    always_comb begin
        dsel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 10'(i)) dsel = bcd_out[4*(NUM_DIGITS-1-i) +: 4];
        end
        hit = hit_raw;
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_q      <= 1'b0;
            font_digit <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            hit_q <= hit;
            if (hit) begin
                font_digit <= dsel;
                row_q      <= dy[3:0];
                col_q      <= col[3:0];
            end
        end
    end

    // row/col only move on a hit, so the ROM index stays within 0..13
    assign pix = font_in[row_q][col_q];
    assign lit = hit_q && (pix != 6'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_on    <= 1'b0;
            pixel_color <= '0;
        end else begin
            pixel_on    <= lit;
            pixel_color <= lit ? pix : 6'd0;
        end
    end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Scoreboard bench for score_digit_ctrl: BCD commits and pixel pipeline.
// Font model: lit if row<2, col<2 or (row+col+d)%4==0; colour d (63 for 0).
module tb_score_digit_ctrl;

    logic                   Clk = 1'b0;
    logic                   Reset_n = 1'b0;
    logic [13:0]            score_in = '0;
    logic                   score_load = 1'b0;
    logic                   busy, conv_done;
    logic [15:0]            bcd_out;
    logic [9:0]             DrawX = '0, DrawY = '0;
    logic [3:0]             font_digit;
    logic [13:0][13:0][5:0] font_in;
    logic                   pixel_on;
    logic [5:0]             pixel_color;

    int checks = 0;
    int errors = 0;

    logic [15:0] bcd_q[$];
    logic [6:0]  pix_q[$];
    logic        probe = 1'b0;
    logic [1:0]  pv = '0;

    score_digit_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .score_in(score_in), .score_load(score_load),
        .busy(busy), .conv_done(conv_done), .bcd_out(bcd_out),
        .DrawX(DrawX), .DrawY(DrawY), .font_digit(font_digit),
        .font_in(font_in), .pixel_on(pixel_on), .pixel_color(pixel_color)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < 14; c++) begin
                if (r < 2 || c < 2 || ((r + c + int'(font_digit)) % 4) == 0)
                    font_in[r][c] = (font_digit == 4'd0) ? 6'd63 : {2'b0, font_digit};
                else
                    font_in[r][c] = 6'd0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // commit monitor
    always @(negedge Clk) begin
        if (Reset_n && conv_done) begin
            if (bcd_q.size() == 0) begin
                check("unexpected_commit", int'(bcd_out), -1);
            end else begin
                check("bcd_commit", int'(bcd_out), int'(bcd_q.pop_front()));
            end
        end
    end

    // pixel monitor: a probe's answer appears two edges later
    always @(posedge Clk) pv <= {pv[0], probe};

    always @(negedge Clk) begin
        if (pv[1]) begin
            if (pix_q.size() == 0) begin
                check("pixel_unexpected", 0, -1);
            end else begin
                check("pixel", int'({pixel_on, pixel_color}), int'(pix_q.pop_front()));
            end
        end
    end

    task automatic load(input int v, input logic [15:0] exp);
        score_in   = 14'(v);
        score_load = 1'b1;
        bcd_q.push_back(exp);
        tick();
        score_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bcd_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("wait_timeout", n, -1);
    endtask

    task automatic px(input int x, input int y, input logic on, input int colr);
        DrawX = 10'(x);
        DrawY = 10'(y);
        probe = 1'b1;
        pix_q.push_back({on, 6'(colr)});
        tick();
        probe = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(conv_done), 0);
        check("rst_bcd", int'(bcd_out), 0);
        check("rst_font_digit", int'(font_digit), 0);
        check("rst_pixel", int'({pixel_on, pixel_color}), 0);
        tick();
        Reset_n = 1'b1;
        tick();

        // 1234: busy cycles 1..15, commit at 15
        load(1234, 16'h1234);
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("busy_c%0d", c), int'(busy), (c <= 15) ? 1 : 0);
            check($sformatf("done_c%0d", c), int'(conv_done), (c == 15) ? 1 : 0);
            tick();
        end
        check("bcd_1234_hold", int'(bcd_out), 16'h1234);
        wait_idle(40);

        load(16383, 16'h9999);
        wait_idle(40);

        // pending: 42 is overwritten by 77 before the first commit
        bcd_q.push_back(16'h0005);
        bcd_q.push_back(16'h0077);
        for (int c = 0; c <= 31; c++) begin
            score_load = (c == 0 || c == 3 || c == 5);
            score_in   = (c == 0) ? 14'd5 : (c == 3) ? 14'd42 : 14'd77;
            if (c > 0)
                check($sformatf("pend_done_c%0d", c), int'(conv_done),
                      (c == 15 || c == 30) ? 1 : 0);
            tick();
        end
        score_load = 1'b0;
        wait_idle(40);

        load(1234, 16'h1234);
        wait_idle(40);

        // pixel probes on 1234, back to back
        px(503, 16, 1'b1, 2);
        check("font_digit_2", int'(font_digit), 2);
        px(494, 16, 1'b0, 0);
        px(479, 16, 1'b0, 0);
        px(535, 29, 1'b1, 4);
        px(535, 30, 1'b0, 0);
        px(502, 21, 1'b0, 0);
        px(481, 25, 1'b1, 1);
        px(544, 16, 1'b0, 0);
        tick();
        tick();
        tick();

        // reset mid-conversion
        score_in   = 14'd1234;
        score_load = 1'b1;
        tick();
        score_load = 1'b0;
        repeat (6) tick();
        Reset_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(conv_done), 0);
        check("midrst_bcd", int'(bcd_out), 0);
        check("midrst_font_digit", int'(font_digit), 0);
        check("midrst_pixel", int'({pixel_on, pixel_color}), 0);
        tick();
        Reset_n = 1'b1;
        repeat (20) tick();
        check("midrst_no_resume", int'(bcd_out), 0);

        load(7, 16'h0007);
        wait_idle(40);
`ifdef LEADING_ZERO_BLANK_EN
        px(487, 16, 1'b0, 0);
        px(503, 16, 1'b0, 0);
        px(519, 16, 1'b0, 0);
`else
        px(487, 16, 1'b1, 63);
        px(503, 16, 1'b1, 63);
        px(519, 16, 1'b1, 63);
`endif
        px(535, 16, 1'b1, 7);
        tick();
        tick();
        tick();

        check("bcd_q_drained", bcd_q.size(), 0);
        check("pix_q_drained", pix_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_digit_ctrl.md
Name: score_digit_ctrl

Overview:
Sequencer for the shared 14x14 digit-font ROM used by the score HUD. Converts a binary score into BCD with a multi-cycle shift-add-3 FSM and commits the BCD atomically. Maps the current VGA pixel (DrawX/DrawY) onto one digit slot and drives the font ROM's digit select. Returns the font pixel as a registered colour, with a fixed 2-cycle latency.

Parameters:
NUM_DIGITS, 4, number of displayed decimal digits; digit 0 is leftmost (most significant).
BIN_W, 14, width of the binary score input.
ORIGIN_X, 480, left pixel column of the digit field.
ORIGIN_Y, 16, top pixel row of the digit field.
PITCH_LOG2, 4, log2 of the horizontal digit pitch (16 px = 14 px glyph + 2 px gap).

Ports:
Clk  in  1  system clock, all state on the rising edge
Reset_n  in  1  asynchronous active-low reset
score_in  in  BIN_W  binary score, sampled when score_load=1
score_load  in  1  single-cycle request to convert score_in
busy  out  1  conversion in progress (CONV or COMMIT state)
conv_done  out  1  one-cycle pulse when bcd_out updates
bcd_out  out  4*NUM_DIGITS  committed BCD; digit 0 in the top nibble
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
font_digit  out  4  digit select to the font ROM (registered)
font_in  in  14*14*6  combinational glyph from the font ROM; [row][col][6-bit colour]
pixel_on  out  1  current pipelined pixel is a lit glyph pixel
pixel_color  out  6  colour of the lit pixel; 0 when pixel_on=0

Behaviour:
- Reset (async, Reset_n=0): state IDLE; busy, conv_done, pixel_on=0; bcd_out, pixel_color, font_digit=0; pending flag cleared.
- Saturation: a score_in above 10^NUM_DIGITS-1 is clamped to that value (9999 by default) when latched.
- FSM states: IDLE, CONV, COMMIT.
- IDLE + score_load: latch the clamped score, clear the scratch BCD, set iteration counter to BIN_W, go to CONV.
- CONV, each cycle: add 3 to every scratch nibble >=5, then shift {scratch, shreg} left 1 (MSB first). Decrement the counter. At count 1, go to COMMIT.
- COMMIT: bcd_out <= scratch; conv_done=1 for this cycle only. If pending is set, reload from the pending value and go to CONV. Otherwise go to IDLE.
- Latency: a score_load accepted in IDLE at cycle 0 gives bcd_out updated and conv_done high at cycle BIN_W+1 (15 by default).
- score_load while busy:
  - The value is captured into a 1-deep pending register; the last load wins and earlier pending values are dropped.
  - A score_load in the same cycle as COMMIT goes to pending.
- Rendering always uses the committed bcd_out. No partial or scratch value is ever displayed.
- Render stage 0 (registered):
  - dx = DrawX-ORIGIN_X; dy = DrawY-ORIGIN_Y.
  - hit = DrawX>=ORIGIN_X && dx < NUM_DIGITS<<PITCH_LOG2 && DrawY>=ORIGIN_Y && dy<14 && col<14.
  - idx = dx>>PITCH_LOG2; col = dx mod pitch; row = dy.
  - font_digit <= bcd nibble idx when hit; font_digit holds its previous value when not hit.
  - Register hit, row and col alongside font_digit.
- Render stage 1 (registered):
  - pix = font_in[row][col].
  - pixel_on <= hit && pix!=0; pixel_color <= pixel_on ? pix : 0.
- Render latency: DrawX/DrawY at cycle n produces pixel_on/pixel_color at cycle n+2. The pipeline is independent of the conversion FSM.
- Reset_n mid-conversion: the conversion is aborted, pending is cleared, and bcd_out returns to 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: stage 0 forces hit=0 for digit idx<NUM_DIGITS-1 when it and all more-significant digits are 0. The least-significant digit is always shown, so a score of 0 displays "0".
- Undefined: all NUM_DIGITS digits are rendered, including leading zeros.

Test Plan:
- Load 1234 at cycle 0 -> busy=1 for cycles 1-15; conv_done pulses at cycle 15; bcd_out=16'h1234.
- Load 16383 -> bcd_out=16'h9999 (saturated).
- Loads of 5 (cycle 0), 42 (cycle 3), 77 (cycle 5) -> first commit 16'h0005, second commit 16'h0077 30 cycles after the first load; 42 never appears.
- Pixel lookup with bcd_out=16'h1234, DrawX=ORIGIN_X+16+7, DrawY=ORIGIN_Y:
  - font_digit=2 one cycle later.
  - With the standard "2" glyph, pixel_on=1 and pixel_color=2 two cycles later.
- Gap and outside pixels: DrawX=ORIGIN_X+14, and DrawX=ORIGIN_X-1 -> pixel_on=0, pixel_color=0 two cycles later.
- Reset_n low at cycle 7 of converting 1234 -> all outputs 0 immediately.
- Reset then load 7 -> with LEADING_ZERO_BLANK_EN, digits 0-2 are dark and digit 3 is lit; without the macro, all four digits are lit.
